// File: rtl/message_packet_arbiter_if.sv
// message_packet_arbiter_if: request/grant and data bus between streams and the packet arbiter
// Signals: req/in_nd/in_data from streams, gnt/out_data/out_nd/busy/error from the arbiter.
// Modports: master drives the stream side, slave is the arbiter.
interface message_packet_arbiter_if #(
    parameter int N_STREAMS = 2,
    parameter int WIDTH = 32
);
    logic [N_STREAMS-1:0] req;
    logic [N_STREAMS-1:0] gnt;
    logic [N_STREAMS*WIDTH-1:0] in_data;
    logic [N_STREAMS-1:0] in_nd;
    logic [WIDTH-1:0] out_data;
    logic out_nd;
    logic busy;
    logic error;
    modport master (output req, in_data, in_nd, input gnt, out_data, out_nd, busy, error);
    modport slave (input req, in_data, in_nd, output gnt, out_data, out_nd, busy, error);
endinterface

// File: rtl/message_packet_arbiter.sv
// message_packet_arbiter: round-robin packet arbiter forwarding one header+body message at a time
// Ports: clk, reset (async, active-high), bus (slave modport: req, gnt, in_data, in_nd, out_data, out_nd, busy, error).
// Optional: define MESSAGE_ARBITER_TIMEOUT_EN to abort grants idle for TIMEOUT cycles.
module message_packet_arbiter #(
    parameter int N_STREAMS = 2,
    parameter int WIDTH = 32,
    parameter int MSG_LENGTH_WIDTH = 8,
    parameter int MAX_PACKET_LENGTH = 64,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic reset,
    message_packet_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_STREAMS);
    typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;
    state_t state, state_n;
    logic [IW-1:0] ptr, ptr_n, gidx, gidx_n, sel, nxt;
    logic found, nd, rel, out_nd_n, error_n;
    logic [N_STREAMS-1:0] gnt_n;
    logic [MSG_LENGTH_WIDTH-1:0] cnt, cnt_n, len;
    logic [WIDTH-1:0] word, out_data_n;
`ifdef MESSAGE_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_n;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif
    assign word = bus.in_data[int'(gidx)*WIDTH +: WIDTH];
    assign nd = bus.in_nd[gidx] && state != IDLE;
    assign len = word[MSG_LENGTH_WIDTH-1:0];
    assign nxt = (gidx == IW'(N_STREAMS - 1)) ? '0 : gidx + 1'b1;
    assign bus.busy = state != IDLE;
    // first requester at or above the pointer, wrapping
    always_comb begin
        sel = ptr;
        found = 1'b0;
        for (int k = 0; k < N_STREAMS; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N_STREAMS;
            if (!found && bus.req[idx]) begin
                sel = IW'(idx);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        gidx_n = gidx;
        gnt_n = bus.gnt;
        cnt_n = cnt;
        out_data_n = bus.out_data;
        out_nd_n = 1'b0;
        rel = 1'b0;
        // gnt is zero in IDLE, so this also flags any strobe while idle
        error_n = bus.error | (|(bus.in_nd & ~bus.gnt));
`ifdef MESSAGE_ARBITER_TIMEOUT_EN
        tcnt_n = '0;
`endif
        if (state == IDLE) begin
            if (found) begin
                state_n = HEADER;
                gidx_n = sel;
                gnt_n = '0;
                gnt_n[sel] = 1'b1;
            end
        end else if (nd) begin
            if (state == HEADER && (!word[WIDTH-1] || 32'(len) > MAX_PACKET_LENGTH)) begin
                error_n = 1'b1;
                rel = 1'b1;
            end else begin
                out_nd_n = 1'b1;
                out_data_n = word;
                if (state == HEADER && len != '0) begin
                    cnt_n = len;
                    state_n = BODY;
                end else if (state == BODY && cnt != MSG_LENGTH_WIDTH'(1)) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    rel = 1'b1;
                end
            end
        end
`ifdef MESSAGE_ARBITER_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
            error_n = 1'b1;
            rel = 1'b1;
        end else begin
            tcnt_n = tcnt + 1'b1;
        end
`endif
        if (rel) begin
            state_n = IDLE;
            gnt_n = '0;
            cnt_n = '0;
            ptr_n = nxt;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            gidx <= '0;
            cnt <= '0;
            bus.gnt <= '0;
            bus.out_data <= '0;
            bus.out_nd <= 1'b0;
            bus.error <= 1'b0;
`ifdef MESSAGE_ARBITER_TIMEOUT_EN
            tcnt <= '0;
`endif
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            gidx <= gidx_n;
            cnt <= cnt_n;
            bus.gnt <= gnt_n;
            bus.out_data <= out_data_n;
            bus.out_nd <= out_nd_n;
            bus.error <= error_n;
`ifdef MESSAGE_ARBITER_TIMEOUT_EN
            tcnt <= tcnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_message_packet_arbiter.sv
// tb_message_packet_arbiter: directed self-checking bench for message_packet_arbiter
module tb_message_packet_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    message_packet_arbiter_if #(.N_STREAMS(2), .WIDTH(32)) bus();
    message_packet_arbiter #(
        .N_STREAMS(2),
        .WIDTH(32),
        .MSG_LENGTH_WIDTH(8),
        .MAX_PACKET_LENGTH(64),
        .TIMEOUT(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic [1:0] r, input logic [1:0] nd, input logic [31:0] d0, input logic [31:0] d1);
        bus.req = r;
        bus.in_nd = nd;
        bus.in_data = {d1, d0};
        @(posedge clk);
        #1;
    endtask
    task automatic rst_pulse;
        bus.req = '0;
        bus.in_nd = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask
    initial begin
        bus.req = '0;
        bus.in_nd = '0;
        bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_nd", bus.out_nd, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.error, 0);
        reset = 1'b0;
        // single packet, L=3 on stream 0
        cyc(2'b01, 2'b00, 0, 0);
        chk("p1_gnt", bus.gnt, 1);
        chk("p1_busy", bus.busy, 1);
        cyc(2'b01, 2'b01, 32'h80000003, 0);
        chk("p1_hnd", bus.out_nd, 1);
        chk("p1_hdata", bus.out_data, 32'h80000003);
        chk("p1_hgnt", bus.gnt, 1);
        cyc(2'b01, 2'b01, 32'hA1, 0);
        chk("p1_d1", bus.out_data, 32'hA1);
        cyc(2'b01, 2'b01, 32'hA2, 0);
        chk("p1_nd2", bus.out_nd, 1);
        cyc(2'b00, 2'b01, 32'hA3, 0);
        chk("p1_d3", bus.out_data, 32'hA3);
        chk("p1_rel", bus.gnt, 0);
        chk("p1_idle", bus.busy, 0);
        cyc(2'b00, 2'b00, 0, 0);
        chk("p1_ndoff", bus.out_nd, 0);
        chk("p1_err", bus.error, 0);
        // both requesting: grants alternate starting at stream 1
        cyc(2'b11, 2'b00, 0, 0);
        chk("rr_g1", bus.gnt, 2);
        cyc(2'b11, 2'b10, 0, 32'h80000002);
        chk("rr_h1", bus.out_data, 32'h80000002);
        cyc(2'b11, 2'b10, 0, 32'hB1);
        cyc(2'b11, 2'b10, 0, 32'hB2);
        chk("rr_rel1", bus.gnt, 0);
        chk("rr_d1", bus.out_data, 32'hB2);
        cyc(2'b11, 2'b00, 0, 0);
        chk("rr_g0", bus.gnt, 1);
        chk("rr_gap", bus.out_nd, 0);
        cyc(2'b11, 2'b01, 32'h80000002, 0);
        cyc(2'b11, 2'b01, 32'hC1, 0);
        cyc(2'b11, 2'b01, 32'hC2, 0);
        chk("rr_rel0", bus.gnt, 0);
        chk("rr_d0", bus.out_data, 32'hC2);
        cyc(2'b11, 2'b00, 0, 0);
        chk("rr_g1b", bus.gnt, 2);
        // zero-length packet on stream 1
        cyc(2'b00, 2'b10, 0, 32'h80000000);
        chk("z_nd", bus.out_nd, 1);
        chk("z_data", bus.out_data, 32'h80000000);
        chk("z_rel", bus.gnt, 0);
        chk("z_busy", bus.busy, 0);
        cyc(2'b11, 2'b00, 0, 0);
        chk("z_ptr", bus.gnt, 1);
        // header without bit 31
        cyc(2'b00, 2'b01, 32'h00000005, 0);
        chk("bh_nd", bus.out_nd, 0);
        chk("bh_err", bus.error, 1);
        chk("bh_rel", bus.gnt, 0);
        chk("bh_drop", bus.out_data, 32'h80000000);
        // header length one beyond the maximum
        rst_pulse();
        chk("ol_clr", bus.error, 0);
        cyc(2'b01, 2'b00, 0, 0);
        chk("ol_gnt", bus.gnt, 1);
        cyc(2'b00, 2'b01, 32'h80000041, 0);
        chk("ol_nd", bus.out_nd, 0);
        chk("ol_err", bus.error, 1);
        chk("ol_rel", bus.gnt, 0);
        // maximum length accepted, then reset mid-body
        rst_pulse();
        cyc(2'b01, 2'b00, 0, 0);
        cyc(2'b00, 2'b01, 32'h80000040, 0);
        chk("mx_nd", bus.out_nd, 1);
        chk("mx_busy", bus.busy, 1);
        chk("mx_err", bus.error, 0);
        cyc(2'b00, 2'b01, 32'hD1, 0);
        chk("mx_d1", bus.out_data, 32'hD1);
        reset = 1'b1;
        #1;
        chk("ar_gnt", bus.gnt, 0);
        chk("ar_nd", bus.out_nd, 0);
        chk("ar_data", bus.out_data, 0);
        chk("ar_busy", bus.busy, 0);
        reset = 1'b0;
        cyc(2'b00, 2'b01, 32'hD2, 0);
        chk("in_idle_nd", bus.out_nd, 0);
        chk("in_idle_err", bus.error, 1);
        // stray strobe on the non-granted stream
        rst_pulse();
        cyc(2'b01, 2'b00, 0, 0);
        cyc(2'b00, 2'b01, 32'h80000001, 0);
        chk("st_hnd", bus.out_nd, 1);
        cyc(2'b00, 2'b10, 0, 32'hDEAD);
        chk("st_nd", bus.out_nd, 0);
        chk("st_err", bus.error, 1);
        chk("st_gnt", bus.gnt, 1);
        cyc(2'b00, 2'b01, 32'hE1, 0);
        chk("st_fin", bus.out_nd, 1);
        chk("st_data", bus.out_data, 32'hE1);
        chk("st_rel", bus.gnt, 0);
        // stalled packet
        rst_pulse();
        cyc(2'b01, 2'b00, 0, 0);
        cyc(2'b00, 2'b01, 32'h80000002, 0);
        repeat (9) cyc(2'b00, 2'b00, 0, 0);
        chk("to_hold", bus.gnt, 1);
        cyc(2'b00, 2'b00, 0, 0);
`ifdef MESSAGE_ARBITER_TIMEOUT_EN
        chk("to_gnt", bus.gnt, 0);
        chk("to_err", bus.error, 1);
        chk("to_busy", bus.busy, 0);
`else
        chk("to_gnt", bus.gnt, 1);
        chk("to_err", bus.error, 0);
        chk("to_busy", bus.busy, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
